// File: rtl/ffd_bank_arbiter_if.sv
// Requester-side bundle for ffd_bank_arbiter.
// Defining ARB_LOCK_EN adds the per-requester Lock input.
interface ffd_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       Req;
  logic [NREQ*WIDTH-1:0] Dato;
  logic [NREQ-1:0]       Gnt;
  logic [NREQ-1:0]       Ack;
  logic [WIDTH-1:0]      Q;
  logic [IW-1:0]         Owner;
  logic                  Busy;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]       Lock;
`endif

  modport master (
    output Req, Dato,
`ifdef ARB_LOCK_EN
    output Lock,
`endif
    input  Gnt, Ack, Q, Owner, Busy
  );

  modport slave (
    input  Req, Dato,
`ifdef ARB_LOCK_EN
    input  Lock,
`endif
    output Gnt, Ack, Q, Owner, Busy
  );
endinterface

// File: rtl/ffd_bank_arbiter.sv
// Round-robin write arbiter/sequencer for a shared WIDTH-bit register bank.
// Optional ARB_LOCK_EN: a locked, still-requesting owner is re-granted straight from WRITE.
module ffd_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input logic               Clk,
  input logic               Reset,
  ffd_bank_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state_r;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  ack_r;
  logic [WIDTH-1:0] q_r;
  logic [IW-1:0]    owner_r;
  logic [IW-1:0]    ptr_r;
  logic [IW-1:0]    win_r;
  logic             busy_r;

  logic [IW-1:0]    win_s;
  logic [IW-1:0]    idx_s;
  logic             found_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Pick the first requester after ptr, wrapping around.
  always_comb begin
    win_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = IW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && bus.Req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbitration FSM; the bank load happens only on the GRANT->WRITE edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      ack_r   <= '0;
      q_r     <= '0;
      owner_r <= '0;
      ptr_r   <= IW'(NREQ - 1);
      win_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= '0;
          if (found_s) begin
            win_r   <= win_s;
            gnt_r   <= onehot(win_s);
            busy_r  <= 1'b1;
            state_r <= GRANT;
          end else begin
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        GRANT: begin
          gnt_r <= '0;
          if (bus.Req[win_r]) begin
            q_r     <= bus.Dato[int'(win_r)*WIDTH +: WIDTH];
            ack_r   <= onehot(win_r);
            owner_r <= win_r;
            ptr_r   <= win_r;
            busy_r  <= 1'b1;
            state_r <= WRITE;
          end else begin
            ack_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        WRITE: begin
          ack_r <= '0;
`ifdef ARB_LOCK_EN
          if (bus.Lock[win_r] && bus.Req[win_r]) begin
            gnt_r   <= onehot(win_r);
            busy_r  <= 1'b1;
            state_r <= GRANT;
          end else begin
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
`else
          gnt_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
`endif
        end
        default: begin
          gnt_r   <= '0;
          ack_r   <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.Gnt   = gnt_r;
  assign bus.Ack   = ack_r;
  assign bus.Q     = q_r;
  assign bus.Owner = owner_r;
  assign bus.Busy  = busy_r;
endmodule

// File: tb/tb_ffd_bank_arbiter.sv
// Directed bench for ffd_bank_arbiter (NREQ=4, WIDTH=4); lock scenario only when ARB_LOCK_EN is defined.
module tb_ffd_bank_arbiter;
  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  ffd_bank_arbiter_if #(.NREQ(4), .WIDTH(4)) bus ();

  ffd_bank_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One full transfer for requester w that is expected to win the next arbitration.
  task automatic do_write(input int w, input logic [3:0] qexp);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    step();
    check("gnt", {28'd0, bus.Gnt}, {28'd0, oh});
    check("ack_in_grant", {28'd0, bus.Ack}, 32'd0);
    check("busy_grant", {31'd0, bus.Busy}, 32'd1);
    step();
    check("q", {28'd0, bus.Q}, {28'd0, qexp});
    check("ack", {28'd0, bus.Ack}, {28'd0, oh});
    check("owner", {30'd0, bus.Owner}, w);
    check("gnt_off_write", {28'd0, bus.Gnt}, 32'd0);
    step();
    check("ack_clear", {28'd0, bus.Ack}, 32'd0);
    check("busy_idle", {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    bus.Req  = 4'($urandom);
    bus.Dato = 16'($urandom);
`ifdef ARB_LOCK_EN
    bus.Lock = 4'b0000;
`endif
    step();
    bus.Req = 4'($urandom);
    step();
    check("rst_q", {28'd0, bus.Q}, 32'd0);
    check("rst_gnt", {28'd0, bus.Gnt}, 32'd0);
    check("rst_ack", {28'd0, bus.Ack}, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_owner", {30'd0, bus.Owner}, 32'd0);

    // All requesting: round robin 0,1,2,3,0.
    Reset    = 1'b0;
    bus.Req  = 4'b1111;
    bus.Dato = {4'h4, 4'h3, 4'h2, 4'h1};
    do_write(0, 4'h1);
    do_write(1, 4'h2);
    do_write(2, 4'h3);
    do_write(3, 4'h4);
    do_write(0, 4'h1);
    bus.Req = 4'b0000;
    step();
    check("idle_no_req", {28'd0, bus.Gnt}, 32'd0);

    // Single requester 2.
    bus.Req  = 4'b0100;
    bus.Dato = {4'h4, 4'hA, 4'h2, 4'h1};
    do_write(2, 4'hA);
    bus.Req = 4'b0000;
    step();

    // Withdrawn request: no load, ptr stays at 2.
    bus.Req = 4'b0010;
    step();
    check("wd_gnt", {28'd0, bus.Gnt}, 32'b0010);
    bus.Req = 4'b0000;
    step();
    check("wd_ack", {28'd0, bus.Ack}, 32'd0);
    check("wd_q", {28'd0, bus.Q}, 32'hA);
    check("wd_gnt_off", {28'd0, bus.Gnt}, 32'd0);
    check("wd_busy", {31'd0, bus.Busy}, 32'd0);
    check("wd_owner", {30'd0, bus.Owner}, 32'd2);
    bus.Req = 4'b0011;
    do_write(0, 4'h1);
    bus.Req = 4'b0000;
    step();

    // Reset during GRANT aborts the transfer.
    bus.Req  = 4'b0100;
    bus.Dato = {4'h4, 4'hF, 4'h2, 4'h1};
    step();
    check("rg_gnt", {28'd0, bus.Gnt}, 32'b0100);
    Reset = 1'b1;
    step();
    check("rg_gnt_off", {28'd0, bus.Gnt}, 32'd0);
    check("rg_ack", {28'd0, bus.Ack}, 32'd0);
    check("rg_q", {28'd0, bus.Q}, 32'd0);
    check("rg_busy", {31'd0, bus.Busy}, 32'd0);
    check("rg_owner", {30'd0, bus.Owner}, 32'd0);

    // Requesters 0 and 3 contending; ptr restarts at 3 so 0 goes first.
    Reset    = 1'b0;
    bus.Req  = 4'b1001;
    bus.Dato = {4'h8, 4'h7, 4'h6, 4'h5};
`ifdef ARB_LOCK_EN
    bus.Lock = 4'b1000;
    do_write(0, 4'h5);
    step();
    check("lk_gnt3", {28'd0, bus.Gnt}, 32'b1000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lk_ack3", {28'd0, bus.Ack}, 32'b1000);
      check("lk_q", {28'd0, bus.Q}, 32'h8);
      step();
      check("lk_regrant", {28'd0, bus.Gnt}, 32'b1000);
      check("lk_ack_off", {28'd0, bus.Ack}, 32'd0);
    end
    bus.Lock = 4'b0000;
    step();
    check("lk_last_ack", {28'd0, bus.Ack}, 32'b1000);
    step();
    check("lk_idle", {31'd0, bus.Busy}, 32'd0);
    do_write(0, 4'h5);
`else
    do_write(0, 4'h5);
    do_write(3, 4'h8);
    do_write(0, 4'h5);
    do_write(3, 4'h8);
`endif
    bus.Req = 4'b0000;
    step();
    check("end_idle", {31'd0, bus.Busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
